// File: rtl/snake_body_engine.sv
// Purpose : snake game-logic stage; holds up to MAX_LEN grid segments, moves one cell per step, grows, detects collisions.
// Latency : one cycle; every output is registered and updates on the edge that samples start/step.
// Backpres: none; a step is accepted every cycle in RUN, ignored in IDLE/DEAD (no buffering).
// Ports   : clk, rst (async active-low) | start, step, dir[1:0], grow in |
//           snake_x_o/snake_y_o (4 bits per slot, slot 0 = head), length, game_state, moved out.
// Option  : define SNAKE_BARRIER_EN to make cells (3..6,2) lethal; undefined, they are free cells.
module snake_body_engine #(
    parameter int MAX_LEN  = 10,
    parameter int GRID_W   = 10,
    parameter int GRID_H   = 8,
    parameter int INIT_LEN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [1:0]           dir,
    input  logic                 grow,
    output logic [4*MAX_LEN-1:0] snake_x_o,
    output logic [4*MAX_LEN-1:0] snake_y_o,
    output logic [3:0]           length,
    output logic [2:0]           game_state,
    output logic                 moved
);

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_RUN    = 3'b001;
    localparam logic [2:0] ST_DEAD   = 3'b010;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [3:0] START_Y   = 4'd5;

    // Load pattern: a horizontal line ending at x=0; unused slots sit on the tail.
    function automatic logic [3:0] load_x(input int idx);
        return (idx < INIT_LEN) ? 4'(INIT_LEN - 1 - idx) : 4'd0;
    endfunction

    logic [2:0] state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [1:0] head_dir_q, head_dir_d;
    logic       moved_q, moved_d;
    logic [3:0] seg_x_q [MAX_LEN];
    logic [3:0] seg_x_d [MAX_LEN];
    logic [3:0] seg_y_q [MAX_LEN];
    logic [3:0] seg_y_d [MAX_LEN];

    logic [1:0] eff_dir;
    logic [4:0] hx, hy, nx, ny;
    logic       grow_eff;
    logic [3:0] new_len;
    logic [3:0] tail_idx;
    logic       wall_hit, self_hit, barrier_hit;

    // Reversal is a flip of the low dir bit (up<->down, left<->right).
    assign eff_dir = (dir == (head_dir_q ^ 2'b01)) ? head_dir_q : dir;

    // Next head at 5 bits so that 0-1 wraps to 31 and lands outside the grid.
    always_comb begin
        hx = {1'b0, seg_x_q[0]};
        hy = {1'b0, seg_y_q[0]};
        nx = hx;
        ny = hy;
        case (eff_dir)
            DIR_UP:    ny = hy - 5'd1;
            DIR_DOWN:  ny = hy + 5'd1;
            DIR_LEFT:  nx = hx - 5'd1;
            default:   nx = hx + 5'd1;
        endcase
    end

    // Growing at full length degrades to a plain move.
    assign grow_eff = grow && (len_q < 4'(MAX_LEN));
    assign new_len  = len_q + {3'b000, grow_eff};
    // The new tail is the old segment sitting just before the new tail index.
    assign tail_idx = new_len - 4'd2;

    assign wall_hit = (nx >= 5'(GRID_W)) || (ny >= 5'(GRID_H));

    // Segments 1..new_len-2 stay occupied after the move: that excludes the
    // vacating tail on a plain move and includes it when growing.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(new_len) - 1) && (seg_x_q[i] == nx[3:0]) && (seg_y_q[i] == ny[3:0]))
                self_hit = 1'b1;
        end
    end

`ifdef SNAKE_BARRIER_EN
    assign barrier_hit = (ny == 5'd2) && (nx >= 5'd3) && (nx <= 5'd6);
`else
    assign barrier_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        head_dir_d = head_dir_q;
        moved_d    = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end

        if (start && (state_q != ST_RUN)) begin
            // start beats a same-cycle step outside RUN
            state_d    = ST_RUN;
            len_d      = 4'(INIT_LEN);
            head_dir_d = DIR_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = load_x(i);
                seg_y_d[i] = START_Y;
            end
        end else if (step && (state_q == ST_RUN)) begin
            if (wall_hit || self_hit || barrier_hit) begin
                // body, length and heading freeze at their pre-step values
                state_d = ST_DEAD;
            end else begin
                head_dir_d = eff_dir;
                len_d      = new_len;
                moved_d    = 1'b1;
                seg_x_d[0] = nx[3:0];
                seg_y_d[0] = ny[3:0];
                for (int i = 1; i < MAX_LEN; i++) begin
                    if (i < int'(new_len)) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end else begin
                        seg_x_d[i] = seg_x_q[tail_idx];
                        seg_y_d[i] = seg_y_q[tail_idx];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= 4'(INIT_LEN);
            head_dir_q <= DIR_RIGHT;
            moved_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= load_x(i);
                seg_y_q[i] <= START_Y;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            head_dir_q <= head_dir_d;
            moved_q    <= moved_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
        end
    end

    always_comb begin
        snake_x_o = '0;
        snake_y_o = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            snake_x_o[4*i +: 4] = seg_x_q[i];
            snake_y_o[4*i +: 4] = seg_y_q[i];
        end
    end

    assign length     = len_q;
    assign game_state = state_q;
    assign moved      = moved_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Purpose : scoreboard bench for snake_body_engine against a queue-based snake model.
// Latency : expectations are tagged with the cycle whose falling edge should show them.
// Backpres: n/a; stimulus one input vector per cycle.
module tb_snake_body_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        grow = 1'b0;
    logic [1:0]  dir = 2'b00;
    logic [39:0] snake_x_o, snake_y_o;
    logic [3:0]  length;
    logic [2:0]  game_state;
    logic        moved;

    snake_body_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step       (step),
        .dir        (dir),
        .grow       (grow),
        .snake_x_o  (snake_x_o),
        .snake_y_o  (snake_y_o),
        .length     (length),
        .game_state (game_state),
        .moved      (moved)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tag;
        logic [39:0] x;
        logic [39:0] y;
        logic [3:0]  len;
        logic [2:0]  st;
        logic        mv;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Reference model: body as a list of cells, head first.
    int bx[$];
    int by[$];
    int m_dx, m_dy;
    int m_state;   // 0 idle, 1 run, 2 dead
    bit m_moved;

    task automatic model_load();
        bx.delete(); by.delete();
        bx.push_back(2); bx.push_back(1); bx.push_back(0);
        by.push_back(5); by.push_back(5); by.push_back(5);
        m_dx = 1; m_dy = 0;
    endtask

    task automatic model_step(input logic [1:0] d, input bit gr);
        int ndx, ndy, nx, ny, lim;
        bit dead, growing;
        ndx = (d == 2'b11) ? 1 : (d == 2'b10) ? -1 : 0;
        ndy = (d == 2'b01) ? 1 : (d == 2'b00) ? -1 : 0;
        if (ndx == -m_dx && ndy == -m_dy) begin
            ndx = m_dx; ndy = m_dy;
        end
        nx = bx[0] + ndx;
        ny = by[0] + ndy;
        growing = gr && (bx.size() < 10);
        dead = (nx < 0) || (nx >= 10) || (ny < 0) || (ny >= 8);
        lim = growing ? bx.size() : bx.size() - 1;
        for (int i = 1; i < lim; i++)
            if (bx[i] == nx && by[i] == ny) dead = 1;
`ifdef SNAKE_BARRIER_EN
        if (ny == 2 && nx >= 3 && nx <= 6) dead = 1;
`endif
        if (dead) begin
            m_state = 2;
        end else begin
            bx.push_front(nx); by.push_front(ny);
            if (!growing) begin
                void'(bx.pop_back());
                void'(by.pop_back());
            end
            m_dx = ndx; m_dy = ndy;
            m_moved = 1;
        end
    endtask

    task automatic push_exp(input int tag);
        exp_t e;
        int idx;
        e.tag = tag;
        e.x = '0;
        e.y = '0;
        for (int i = 0; i < 10; i++) begin
            idx = (i < bx.size()) ? i : bx.size() - 1;
            e.x[4*i +: 4] = 4'(bx[idx]);
            e.y[4*i +: 4] = 4'(by[idx]);
        end
        e.len = 4'(bx.size());
        e.st  = 3'(m_state);
        e.mv  = m_moved;
        sb.push_back(e);
    endtask

    // One cycle of stimulus; the expectation applies after the next rising edge.
    task automatic drive(input bit st, input bit sp, input logic [1:0] d, input bit gr);
        @(posedge clk); #1;
        start = st; step = sp; dir = d; grow = gr;
        m_moved = 0;
        if (st && m_state != 1) begin
            model_load();
            m_state = 1;
        end else if (sp && m_state == 1) begin
            model_step(d, gr);
        end
        push_exp(cyc + 1);
    endtask

    // Asynchronous reset pulse between edges; the outputs must change before the next edge.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; start = 0; step = 0; grow = 0;
        #1;
        model_load();
        m_state = 0;
        m_moved = 0;
        while (sb.size() > 0 && sb[$].tag == cyc) void'(sb.pop_back());
        push_exp(cyc);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic chk(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, tag, act, exp);
        end
    endtask

    // Monitor: compares every expectation due on this falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                if (e.tag < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL stale_expectation cycle=%0d got=none expected=tag%0d", cyc, e.tag);
                end else begin
                    chk("snake_x", e.tag, 64'(snake_x_o), 64'(e.x));
                    chk("snake_y", e.tag, 64'(snake_y_o), 64'(e.y));
                    chk("length", e.tag, 64'(length), 64'(e.len));
                    chk("game_state", e.tag, 64'(game_state), 64'(e.st));
                    chk("moved", e.tag, 64'(moved), 64'(e.mv));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    localparam logic [1:0] U = 2'b00, D = 2'b01, L = 2'b10, R = 2'b11;

    initial begin
        model_load();
        m_state = 0;
        m_moved = 0;

        // reset values, then three right moves
        do_reset();
        drive(1, 0, R, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, R, 0);
        drive(0, 0, R, 0);
        // start in RUN ignored, step processed
        drive(1, 1, R, 0);
        // run into the right wall, then ignored inputs in DEAD
        for (int i = 0; i < 5; i++) drive(0, 1, R, 0);
        drive(0, 1, U, 0);
        drive(0, 0, U, 1);
        // start and step together from DEAD: start wins
        drive(1, 1, U, 0);
        // reverse request is ignored
        drive(0, 1, L, 0);
        // grow to the maximum length and one saturating grow
        drive(0, 1, D, 1); drive(0, 1, D, 1); drive(0, 1, L, 1); drive(0, 1, L, 1);
        drive(0, 1, L, 1); drive(0, 1, U, 1); drive(0, 1, U, 1); drive(0, 1, U, 1);
        drive(0, 0, U, 0);

        // barrier cell above (3,3)
        do_reset();
        drive(1, 0, R, 0);
        drive(0, 1, R, 0); drive(0, 1, U, 0); drive(0, 1, U, 0); drive(0, 1, U, 0);
        drive(0, 0, U, 0);

        // square of length 4: stepping onto the vacating tail is legal
        do_reset();
        drive(1, 0, R, 0);
        drive(0, 1, R, 1); drive(0, 1, U, 0); drive(0, 1, L, 0); drive(0, 1, D, 0);
        drive(0, 0, D, 0);
        // same square while growing: the tail stays, so it is lethal
        do_reset();
        drive(1, 0, R, 0);
        drive(0, 1, R, 1); drive(0, 1, U, 0); drive(0, 1, L, 0); drive(0, 1, D, 1);
        drive(0, 0, D, 0);

        // reset right after a committed move
        drive(1, 0, R, 0);
        drive(0, 1, D, 0);
        do_reset();

        // random play
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                      2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
            end
        end
        drive(0, 0, R, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", cyc, 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
